// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore multicycle control FSM for the MIPS-subset datapath.
// Define UC_EXCECAO_EN to enable the illegal-opcode exception path (EXC state).
module controle_multiciclo #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPcode,
  output logic [1:0] SrcPC,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [2:0] ULAOp,
  output logic       EscReg,
  output logic       RegDst,
  output logic       Mem2Reg,
  output logic       IREsc,
  output logic       IorD,
  output logic       WriteMem,
  output logic       StoreMem,
  output logic       PCWri,
  output logic       PCWriCond,
  output logic       Excecao,
  output logic       EPCWri,
  output logic [4:0] state_out
);

  localparam logic [4:0] ST_RESET     = 5'd0;
  localparam logic [4:0] ST_BUSCA     = 5'd1;
  localparam logic [4:0] ST_WAIT      = 5'd2;
  localparam logic [4:0] ST_WRITE     = 5'd3;
  localparam logic [4:0] ST_DECODE    = 5'd4;
  localparam logic [4:0] ST_EXEC_R    = 5'd5;
  localparam logic [4:0] ST_WB_R      = 5'd6;
  localparam logic [4:0] ST_ADDI_EXEC = 5'd7;
  localparam logic [4:0] ST_ADDI_WB   = 5'd8;
  localparam logic [4:0] ST_MEM_ADDR  = 5'd9;
  localparam logic [4:0] ST_LW_READ   = 5'd10;
  localparam logic [4:0] ST_LW_WAIT   = 5'd11;
  localparam logic [4:0] ST_LW_MDR    = 5'd12;
  localparam logic [4:0] ST_LW_WB     = 5'd13;
  localparam logic [4:0] ST_SW_WRITE  = 5'd14;
  localparam logic [4:0] ST_BEQ       = 5'd15;
  localparam logic [4:0] ST_JUMP      = 5'd16;
  localparam logic [4:0] ST_EXC       = 5'd17;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam bit         HasWait     = (MEM_WAIT > 0);
  localparam int         WaitLastInt = (MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0;
  localparam logic [3:0] WAIT_LAST   = 4'(WaitLastInt);

  logic [4:0] state_q, state_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic [5:0] opLatch_q, opLatch_d;

  // Next-state logic; the wait counter is cleared whenever a wait state is entered.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    opLatch_d = opLatch_q;
    case (state_q)
      ST_RESET: state_d = ST_BUSCA;
      ST_BUSCA: begin
        if (HasWait) begin
          state_d   = ST_WAIT;
          waitCnt_d = 4'd0;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WAIT: begin
        if (waitCnt_q == WAIT_LAST) state_d = ST_WRITE;
        else waitCnt_d = waitCnt_q + 4'd1;
      end
      ST_WRITE: state_d = ST_DECODE;
      ST_DECODE: begin
        opLatch_d = OPcode;
        case (OPcode)
          OP_RTYPE:     state_d = ST_EXEC_R;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BEQ;
          OP_J:         state_d = ST_JUMP;
          default: begin
`ifdef UC_EXCECAO_EN
            state_d = ST_EXC;
`else
            state_d = ST_BUSCA;
`endif
          end
        endcase
      end
      ST_EXEC_R:    state_d = ST_WB_R;
      ST_WB_R:      state_d = ST_BUSCA;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_ADDI_WB:   state_d = ST_BUSCA;
      ST_MEM_ADDR:  state_d = (opLatch_q == OP_LW) ? ST_LW_READ : ST_SW_WRITE;
      ST_LW_READ: begin
        if (HasWait) begin
          state_d   = ST_LW_WAIT;
          waitCnt_d = 4'd0;
        end else begin
          state_d = ST_LW_MDR;
        end
      end
      ST_LW_WAIT: begin
        if (waitCnt_q == WAIT_LAST) state_d = ST_LW_MDR;
        else waitCnt_d = waitCnt_q + 4'd1;
      end
      ST_LW_MDR:   state_d = ST_LW_WB;
      ST_LW_WB:    state_d = ST_BUSCA;
      ST_SW_WRITE: state_d = ST_BUSCA;
      ST_BEQ:      state_d = ST_BUSCA;
      ST_JUMP:     state_d = ST_BUSCA;
`ifdef UC_EXCECAO_EN
      ST_EXC:      state_d = ST_BUSCA;
`else
      ST_EXC:      state_d = ST_RESET;
`endif
      default:     state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RESET;
      waitCnt_q <= 4'd0;
      opLatch_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      opLatch_q <= opLatch_d;
    end
  end

  // Moore output decode: everything defaults to 0, so RESET and unused codes are quiet.
  always_comb begin
    SrcPC     = 2'b00;
    ULASrcA   = 1'b0;
    ULASrcB   = 2'b00;
    ULAOp     = 3'b000;
    EscReg    = 1'b0;
    RegDst    = 1'b0;
    Mem2Reg   = 1'b0;
    IREsc     = 1'b0;
    IorD      = 1'b0;
    WriteMem  = 1'b0;
    StoreMem  = 1'b0;
    PCWri     = 1'b0;
    PCWriCond = 1'b0;
    Excecao   = 1'b0;
    EPCWri    = 1'b0;
    case (state_q)
      ST_BUSCA: begin
        ULASrcB = 2'b01;
        PCWri   = 1'b1;
      end
      ST_WAIT:   ULASrcB = 2'b01;
      ST_WRITE:  IREsc   = 1'b1;
      ST_DECODE: ULASrcB = 2'b11;
      ST_EXEC_R: begin
        ULASrcA = 1'b1;
        ULAOp   = 3'b010;
      end
      ST_WB_R: begin
        EscReg = 1'b1;
        RegDst = 1'b1;
      end
      ST_ADDI_EXEC, ST_MEM_ADDR: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
      end
      ST_ADDI_WB: EscReg = 1'b1;
      ST_LW_READ, ST_LW_WAIT: IorD = 1'b1;
      ST_LW_MDR: begin
        IorD     = 1'b1;
        StoreMem = 1'b1;
      end
      ST_LW_WB: begin
        EscReg  = 1'b1;
        Mem2Reg = 1'b1;
      end
      ST_SW_WRITE: begin
        IorD     = 1'b1;
        WriteMem = 1'b1;
      end
      ST_BEQ: begin
        ULASrcA   = 1'b1;
        ULAOp     = 3'b001;
        SrcPC     = 2'b01;
        PCWriCond = 1'b1;
      end
      ST_JUMP: begin
        SrcPC = 2'b10;
        PCWri = 1'b1;
      end
`ifdef UC_EXCECAO_EN
      // EPC captures PC-4, i.e. the address of the offending instruction.
      ST_EXC: begin
        Excecao = 1'b1;
        EPCWri  = 1'b1;
        ULASrcB = 2'b01;
        ULAOp   = 3'b001;
        SrcPC   = 2'b11;
        PCWri   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: scoreboard bench driving three controllers (MEM_WAIT = 1, 3, 0)
// through short instruction programs; expected state paths are queued per instruction.
module tb_controle_multiciclo;

  logic clock = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Control word {SrcPC,ULASrcA,ULASrcB,ULAOp,EscReg,RegDst,Mem2Reg,IREsc,IorD,WriteMem,StoreMem,PCWri,PCWriCond,Excecao,EPCWri}
  function automatic logic [18:0] expCtl(input logic [4:0] s);
    logic [1:0] pcSel, bSel;
    logic [2:0] op;
    logic aSel, esc, dst, m2r, ir, iord, wm, sm, pcw, pcc, exc, epc;
    pcSel = 2'b00; bSel = 2'b00; op = 3'b000; aSel = 0;
    esc = 0; dst = 0; m2r = 0; ir = 0; iord = 0; wm = 0; sm = 0; pcw = 0; pcc = 0; exc = 0; epc = 0;
    case (s)
      5'd1:  begin bSel = 2'b01; pcw = 1; end
      5'd2:  bSel = 2'b01;
      5'd3:  ir = 1;
      5'd4:  bSel = 2'b11;
      5'd5:  begin aSel = 1; op = 3'b010; end
      5'd6:  begin esc = 1; dst = 1; end
      5'd7:  begin aSel = 1; bSel = 2'b10; end
      5'd8:  esc = 1;
      5'd9:  begin aSel = 1; bSel = 2'b10; end
      5'd10: iord = 1;
      5'd11: iord = 1;
      5'd12: begin iord = 1; sm = 1; end
      5'd13: begin esc = 1; m2r = 1; end
      5'd14: begin iord = 1; wm = 1; end
      5'd15: begin aSel = 1; op = 3'b001; pcSel = 2'b01; pcc = 1; end
      5'd16: begin pcSel = 2'b10; pcw = 1; end
`ifdef UC_EXCECAO_EN
      5'd17: begin exc = 1; epc = 1; bSel = 2'b01; op = 3'b001; pcSel = 2'b11; pcw = 1; end
`endif
      default: ;
    endcase
    return {pcSel, aSel, bSel, op, esc, dst, m2r, ir, iord, wm, sm, pcw, pcc, exc, epc};
  endfunction

  // Full state path of one instruction; returns its length and the k-th state in st.
  function automatic int buildPath(input logic [5:0] opc, input int w, input int k, output logic [4:0] st);
    logic [4:0] p [48];
    int n;
    n = 0;
    p[n] = 5'd1; n++;
    for (int i = 0; i < w; i++) begin p[n] = 5'd2; n++; end
    p[n] = 5'd3; n++;
    p[n] = 5'd4; n++;
    case (opc)
      6'h00: begin p[n] = 5'd5; n++; p[n] = 5'd6; n++; end
      6'h08: begin p[n] = 5'd7; n++; p[n] = 5'd8; n++; end
      6'h23: begin
        p[n] = 5'd9; n++; p[n] = 5'd10; n++;
        for (int i = 0; i < w; i++) begin p[n] = 5'd11; n++; end
        p[n] = 5'd12; n++; p[n] = 5'd13; n++;
      end
      6'h2B: begin p[n] = 5'd9; n++; p[n] = 5'd14; n++; end
      6'h04: begin p[n] = 5'd15; n++; end
      6'h02: begin p[n] = 5'd16; n++; end
      default: begin
`ifdef UC_EXCECAO_EN
        p[n] = 5'd17; n++;
`endif
      end
    endcase
    st = (k < n) ? p[k] : 5'd0;
    return n;
  endfunction

  // Programs: opcode entries, -1 = LW aborted by reset in LW_WAIT, -2 = end.
  function automatic int progAt(input int u, input int i);
    int a0[9] = '{0, 8, 4, 2, 35, 43, 63, 0, -2};
    int a1[7] = '{35, -1, 35, 43, 63, 4, -2};
    int a2[8] = '{43, 35, 0, 4, 63, 2, 8, -2};
    case (u)
      0:       return a0[i];
      1:       return a1[i];
      default: return a2[i];
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    logic rstI = 1'b1;
    logic [5:0] opc = 6'd0;
    logic [1:0] srcPC, bSel;
    logic [2:0] aluOp;
    logic aSel, escReg, regDst, mem2Reg, irEsc, iorD, writeMem, storeMem, pcWri, pcWriCond, excecao, epcWri;
    logic [4:0] stOut;
    logic [18:0] ctlObs;
    bit done = 1'b0;
    logic [4:0] expQ [$];

    controle_multiciclo #(.MEM_WAIT(W)) dut (
      .clock(clock), .reset(rstI), .OPcode(opc),
      .SrcPC(srcPC), .ULASrcA(aSel), .ULASrcB(bSel), .ULAOp(aluOp),
      .EscReg(escReg), .RegDst(regDst), .Mem2Reg(mem2Reg), .IREsc(irEsc),
      .IorD(iorD), .WriteMem(writeMem), .StoreMem(storeMem), .PCWri(pcWri),
      .PCWriCond(pcWriCond), .Excecao(excecao), .EPCWri(epcWri), .state_out(stOut)
    );

    assign ctlObs = {srcPC, aSel, bSel, aluOp, escReg, regDst, mem2Reg, irEsc, iorD,
                     writeMem, storeMem, pcWri, pcWriCond, excecao, epcWri};

    initial begin
      int idx, cyc, entry, abortPhase, n;
      logic [4:0] st, e;
      idx = 0; cyc = 0; abortPhase = 0;
      // Hold reset for two edges; the controller must sit quietly in RESET.
      repeat (2) begin
        @(negedge clock);
        expQ.push_back(5'd0);
        e = expQ.pop_front();
        checkOutput($sformatf("u%0d rst state", g), 32'(stOut), 32'(e));
        checkOutput($sformatf("u%0d rst ctl", g), 32'(ctlObs), 32'(expCtl(e)));
      end
      rstI = 1'b0;
      while (!done && cyc < 400) begin
        @(negedge clock);
        cyc++;
        if (expQ.size() == 0) begin
          if (abortPhase == 1) begin
            expQ.push_back(5'd11);
            rstI = 1'b1;
            abortPhase = 2;
          end else if (abortPhase == 2) begin
            expQ.push_back(5'd0);
            rstI = 1'b0;
            abortPhase = 0;
          end else begin
            entry = progAt(g, idx);
            idx++;
            if (entry == -2) begin
              done = 1'b1;
            end else if (entry == -1) begin
              opc = 6'h23;
              for (int k = 0; k < W + 6; k++) begin
                void'(buildPath(opc, W, k, st));
                expQ.push_back(st);
              end
              abortPhase = 1;
            end else begin
              opc = entry[5:0];
              n = buildPath(opc, W, 0, st);
              for (int k = 0; k < n; k++) begin
                void'(buildPath(opc, W, k, st));
                expQ.push_back(st);
              end
            end
          end
        end
        if (!done) begin
          e = expQ.pop_front();
          checkOutput($sformatf("u%0d c%0d state", g, cyc), 32'(stOut), 32'(e));
          checkOutput($sformatf("u%0d c%0d ctl", g, cyc), 32'(ctlObs), 32'(expCtl(e)));
        end
      end
      if (!done) begin
        checkOutput($sformatf("u%0d program timeout", g), 32'd0, 32'd1);
        done = 1'b1;
      end
    end
  end

  initial begin
    bit allDone;
    allDone = 1'b0;
    for (int t = 0; t < 3000 && !allDone; t++) begin
      @(posedge clock);
      allDone = inst[0].done && inst[1].done && inst[2].done;
    end
    if (!allDone) checkOutput("global timeout", 32'd0, 32'd1);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
